// File: rtl/lamp_mode_ctrl.sv
// rtl/lamp_mode_ctrl.sv - button debounce, mode arbitration and scan/frame sequencing for the lamp matrix
//
// Purpose
//    Sequencer for the 16x16 dot-matrix turn/brake lamp. The three raw buttons
//    are synchronised and debounced. They are then arbitrated into one display
//    mode, with brake taking priority. The block also produces the free-running
//    column scan index and the per-mode animation frame index. Everything runs
//    on clk, so there is no slow clock domain.
//
// Parameters
//    SCAN_DIV   clk cycles per column step (>=2)
//    FRAME_DIV  clk cycles per animation frame (>=2)
//    DB_CYCLES  consecutive stable cycles before a button change is accepted (>=1)
//    NFRAMES    animation frames per cycle, 1..4
//
// Ports
//    clk        in   1   system clock
//    rst        in   1   synchronous active-high reset
//    btn_left   in   1   raw left-turn button, asynchronous
//    btn_right  in   1   raw right-turn button, asynchronous
//    btn_brake  in   1   raw brake button, asynchronous
//    col        out  4   column index to the scanner, 0..15
//    col_en     out  1   single-cycle pulse in the cycle col advances
//    frame      out  2   animation frame index, 0..NFRAMES-1
//    mode       out  2/3 0=IDLE 1=LEFT 2=RIGHT 3=BRAKE (4=HAZARD when enabled)
//    stop       out  1   mode is BRAKE
//    left       out  1   mode is LEFT
//
// Build option
//    LAMP_HAZARD_EN  adds a HAZARD state (mode becomes 3 bits, 4=HAZARD).
//                    Both turn buttons held without brake select HAZARD, which
//                    animates like a turn state. Brake still overrides it.

module lamp_mode_ctrl #(
   parameter int SCAN_DIV  = 3125,
   parameter int FRAME_DIV = 50000000,
   parameter int DB_CYCLES = 500000,
   parameter int NFRAMES   = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_left,
   input  logic       btn_right,
   input  logic       btn_brake,
   output logic [3:0] col,
   output logic       col_en,
   output logic [1:0] frame,
`ifdef LAMP_HAZARD_EN
   output logic [2:0] mode,
`else
   output logic [1:0] mode,
`endif
   output logic       stop,
   output logic       left
);

   // ------------------------------------------------------------------
   // Counter widths and terminal values
   // ------------------------------------------------------------------
   localparam int SCAN_W  = $clog2(SCAN_DIV);
   localparam int FRAME_W = $clog2(FRAME_DIV);
   localparam int DB_W    = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

   localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
   localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(FRAME_DIV - 1);
   localparam logic [DB_W-1:0]    DB_LAST    = DB_W'(DB_CYCLES - 1);
   localparam logic [1:0]         FRAME_TOP  = 2'(NFRAMES - 1);

   // ------------------------------------------------------------------
   // State encoding; the state register value is the mode output
   // ------------------------------------------------------------------
`ifdef LAMP_HAZARD_EN
   localparam int ST_W = 3;
`else
   localparam int ST_W = 2;
`endif
   localparam logic [ST_W-1:0] ST_IDLE   = ST_W'(0);
   localparam logic [ST_W-1:0] ST_LEFT   = ST_W'(1);
   localparam logic [ST_W-1:0] ST_RIGHT  = ST_W'(2);
   localparam logic [ST_W-1:0] ST_BRAKE  = ST_W'(3);
`ifdef LAMP_HAZARD_EN
   localparam logic [ST_W-1:0] ST_HAZARD = ST_W'(4);
`endif

   // ------------------------------------------------------------------
   // Input synchronisers (bit 0 = left, 1 = right, 2 = brake)
   // ------------------------------------------------------------------
   logic [2:0] btn_raw;
   logic [2:0] sync1_q;
   logic [2:0] sync2_q;
   logic [2:0] deb;

   assign btn_raw = {btn_brake, btn_right, btn_left};

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= btn_raw;
         sync2_q <= sync1_q;
      end
   end

   // ------------------------------------------------------------------
   // Debouncers: the counter tracks consecutive cycles where the synced
   // input disagrees with the accepted value. Agreement (a bounce back)
   // clears it. On the DB_CYCLES-th disagreeing cycle the new value is
   // taken and the count starts over.
   // ------------------------------------------------------------------
   for (genvar b = 0; b < 3; b++) begin : g_db
      logic [DB_W-1:0] cnt_q;
      logic [DB_W-1:0] cnt_d;
      logic            deb_q;
      logic            deb_d;

      always_comb begin
         cnt_d = '0;
         deb_d = deb_q;
         if (sync2_q[b] != deb_q) begin
            if (cnt_q == DB_LAST) begin
               deb_d = sync2_q[b];
            end else begin
               cnt_d = cnt_q + DB_W'(1);
            end
         end
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            cnt_q <= '0;
            deb_q <= 1'b0;
         end else begin
            cnt_q <= cnt_d;
            deb_q <= deb_d;
         end
      end

      assign deb[b] = deb_q;
   end

   // ------------------------------------------------------------------
   // Mode arbitration
   // ------------------------------------------------------------------
   logic            dl;
   logic            dr;
   logic            db;
   logic [ST_W-1:0] state_q;
   logic [ST_W-1:0] state_d;
   logic            animate_d;
   logic            mode_change;

   assign dl = deb[0];
   assign dr = deb[1];
   assign db = deb[2];

   always_comb begin
      state_d = ST_IDLE;
      if (db) begin
         state_d = ST_BRAKE;
      end else if (dl && !dr) begin
         state_d = ST_LEFT;
      end else if (!dl && dr) begin
         state_d = ST_RIGHT;
`ifdef LAMP_HAZARD_EN
      end else if (dl && dr) begin
         state_d = ST_HAZARD;
`endif
      end else begin
         state_d = ST_IDLE;
      end
   end

   // Animating states run the frame divider. IDLE and BRAKE hold it cleared.
`ifdef LAMP_HAZARD_EN
   assign animate_d = (state_d == ST_LEFT) || (state_d == ST_RIGHT) ||
                      (state_d == ST_HAZARD);
`else
   assign animate_d = (state_d == ST_LEFT) || (state_d == ST_RIGHT);
`endif

   assign mode_change = (state_d != state_q);

   // stop/left come from the next state so they change on the same edge as mode.
   logic stop_q;
   logic left_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         stop_q  <= 1'b0;
         left_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         stop_q  <= (state_d == ST_BRAKE);
         left_q  <= (state_d == ST_LEFT);
      end
   end

   // ------------------------------------------------------------------
   // Frame sequencing. A mode change clears the divider and frame on that
   // same edge, even if a frame tick was due, so the first frame of the new
   // mode lasts the full FRAME_DIV cycles.
   // ------------------------------------------------------------------
   logic [FRAME_W-1:0] fdiv_q;
   logic [FRAME_W-1:0] fdiv_d;
   logic [1:0]         frame_q;
   logic [1:0]         frame_d;

   always_comb begin
      fdiv_d  = '0;
      frame_d = '0;
      if (!mode_change && animate_d) begin
         if (fdiv_q == FRAME_LAST) begin
            fdiv_d  = '0;
            frame_d = (frame_q == FRAME_TOP) ? 2'd0 : frame_q + 2'd1;
         end else begin
            fdiv_d  = fdiv_q + FRAME_W'(1);
            frame_d = frame_q;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fdiv_q  <= '0;
         frame_q <= '0;
      end else begin
         fdiv_q  <= fdiv_d;
         frame_q <= frame_d;
      end
   end

   // ------------------------------------------------------------------
   // Column scan. This runs free in every mode. col_en is registered with
   // col, so the pulse lines up with the new column value.
   // ------------------------------------------------------------------
   logic [SCAN_W-1:0] scan_q;
   logic [SCAN_W-1:0] scan_d;
   logic [3:0]        col_q;
   logic [3:0]        col_d;
   logic              col_en_q;
   logic              col_en_d;

   always_comb begin
      scan_d   = scan_q + SCAN_W'(1);
      col_d    = col_q;
      col_en_d = 1'b0;
      if (scan_q == SCAN_LAST) begin
         scan_d   = '0;
         col_d    = col_q + 4'd1;
         col_en_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         scan_q   <= '0;
         col_q    <= '0;
         col_en_q <= 1'b0;
      end else begin
         scan_q   <= scan_d;
         col_q    <= col_d;
         col_en_q <= col_en_d;
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign col    = col_q;
   assign col_en = col_en_q;
   assign frame  = frame_q;
   assign mode   = state_q;
   assign stop   = stop_q;
   assign left   = left_q;

endmodule

// File: tb/tb_lamp_mode_ctrl.sv
// tb/tb_lamp_mode_ctrl.sv - randomized self-checking bench for lamp_mode_ctrl against a behavioural model

module tb_lamp_mode_ctrl;

   localparam int SD = 4;
   localparam int FD = 16;
   localparam int DB = 3;
   localparam int NF = 2;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       btn_left = 1'b0;
   logic       btn_right = 1'b0;
   logic       btn_brake = 1'b0;
   logic [3:0] col;
   logic       col_en;
   logic [1:0] frame;
`ifdef LAMP_HAZARD_EN
   logic [2:0] mode;
`else
   logic [1:0] mode;
`endif
   logic       stop;
   logic       left;

   lamp_mode_ctrl #(
      .SCAN_DIV  (SD),
      .FRAME_DIV (FD),
      .DB_CYCLES (DB),
      .NFRAMES   (NF)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .btn_left  (btn_left),
      .btn_right (btn_right),
      .btn_brake (btn_brake),
      .col       (col),
      .col_en    (col_en),
      .frame     (frame),
      .mode      (mode),
      .stop      (stop),
      .left      (left)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         if (n_err <= 40)
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // ------------------------------------------------------------------
   // Reference model. It keeps a raw-sample history per button and a window
   // of the last DB samples the debouncer saw. A button is accepted when the
   // whole window shows the opposite of the accepted value. Frame and column
   // come from elapsed-cycle arithmetic.
   // ------------------------------------------------------------------
   bit m_s1  [3];
   bit m_s2  [3];
   bit m_deb [3];
   bit m_win [3][DB];
   int m_mode;
   int m_age;   // edges since the current mode was entered
   int m_n;     // edges since reset

   function automatic int arbitrate(bit l, bit r, bit b);
      if (b) return 3;
      if (l && !r) return 1;
      if (r && !l) return 2;
`ifdef LAMP_HAZARD_EN
      if (l && r) return 4;
`endif
      return 0;
   endfunction

   function automatic bit animating(int m);
      return (m == 1) || (m == 2) || (m == 4);
   endfunction

   task automatic model_step();
      bit raw [3];
      bit flip;
      int nm;
      raw[0] = btn_left;
      raw[1] = btn_right;
      raw[2] = btn_brake;
      if (rst) begin
         for (int b = 0; b < 3; b++) begin
            m_s1[b] = 0;
            m_s2[b] = 0;
            m_deb[b] = 0;
            for (int i = 0; i < DB; i++) m_win[b][i] = 0;
         end
         m_mode = 0;
         m_age  = 0;
         m_n    = 0;
         return;
      end
      nm = arbitrate(m_deb[0], m_deb[1], m_deb[2]);
      if (nm != m_mode) begin
         m_mode = nm;
         m_age  = 0;
      end else begin
         m_age++;
      end
      m_n++;
      for (int b = 0; b < 3; b++) begin
         for (int i = DB - 1; i > 0; i--) m_win[b][i] = m_win[b][i-1];
         m_win[b][0] = m_s2[b];
         flip = 1;
         for (int i = 0; i < DB; i++)
            if (m_win[b][i] == m_deb[b]) flip = 0;
         if (flip) m_deb[b] = !m_deb[b];
         m_s2[b] = m_s1[b];
         m_s1[b] = raw[b];
      end
   endtask

   task automatic tick();
      int exp_frame;
      @(posedge clk);
      model_step();
      cyc++;
      #1;
      exp_frame = animating(m_mode) ? (m_age / FD) % NF : 0;
      chk("mode",   32'(mode),   32'(m_mode));
      chk("stop",   32'(stop),   32'(m_mode == 3));
      chk("left",   32'(left),   32'(m_mode == 1));
      chk("frame",  32'(frame),  32'(exp_frame));
      chk("col",    32'(col),    32'((m_n / SD) % 16));
      chk("col_en", 32'(col_en), 32'((m_n > 0) && (m_n % SD == 0)));
   endtask

   task automatic hold(input bit r, input bit l, input bit rt, input bit b, input int n);
      rst       = r;
      btn_left  = l;
      btn_right = rt;
      btn_brake = b;
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      hold(1, 0, 0, 0, 2);     // reset
      hold(0, 0, 0, 0, 70);    // idle, column wraps
      hold(0, 1, 0, 0, 60);    // left, frame toggles
      hold(0, 1, 0, 1, 2);     // brake glitch, rejected
      hold(0, 1, 0, 0, 10);
      hold(0, 1, 0, 1, 20);    // brake overrides left
      hold(0, 1, 0, 0, 40);    // back to left, frame restarts
      hold(0, 1, 1, 0, 50);    // both turns
      hold(0, 0, 1, 0, 27);    // right, into second frame
      hold(1, 0, 1, 0, 1);     // reset mid-frame
      hold(0, 0, 1, 0, 30);    // re-debounce into right
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 7) == 0) begin
            btn_left  = 1'($urandom_range(0, 1));
            btn_right = 1'($urandom_range(0, 1));
            btn_brake = 1'($urandom_range(0, 1));
         end
         rst = ($urandom_range(0, 399) == 0);
         tick();
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
